mod_dispatch: RTL

MOD_DISPATCH -- requirements
Module: mod_dispatch

---
 rtl/mod_dispatch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mod_dispatch.sv
// Operation dispatcher: routes the selected engine's output stream into the destination
// FIFO, gates source-FIFO pops, and sequences operation start, end, abort and error.
module mod_dispatch #(
    parameter int             DW  = 64,
    parameter int             NE  = 4,
    parameter logic [NE-1:0]  CAP = 4'b0110
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               m_enable,
    input  logic [23:0]        dc,
    input  logic [DW-1:0]      m_src,
    input  logic               m_src_last,
    input  logic               m_src_empty,
    input  logic               m_src_almost_empty,
    output logic               m_src_getn,
    output logic [DW-1:0]      m_dst,
    output logic               m_dst_last,
    output logic               m_dst_putn,
    input  logic               m_dst_full,
    input  logic               m_dst_almost_full,
    output logic               m_endn,
    output logic               m_err,
    output logic [7:0]         m_cap,
    output logic [15:0]        m_count,
    output logic [NE-1:0]      e_ce,
    input  logic [NE-1:0]      e_getn,
    input  logic [NE*DW-1:0]   e_data,
    input  logic [NE-1:0]      e_valid,
    input  logic [NE-1:0]      e_last,
    input  logic [NE-1:0]      e_done,
    output logic               e_src_empty,
    output logic               e_fo_full
);

    localparam int SW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, END, ERR, HOLD} state_t;

    state_t          state_q, state_d;
    logic [NE-1:0]   op_q, op_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   dst_q, dst_d;
    logic            last_q, last_d;
    logic            putn_q, putn_d;
    logic [15:0]     count_q, count_d;
    logic            err_q, err_d;

    logic [NE-1:0]   op_in;
    logic [SW-1:0]   sel_c;
    logic            op_legal;
    logic            accept;
    logic [DW-1:0]   e_lane [NE];
    logic            in_unused;

    assign op_in = dc[4 +: NE];

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_lane
            assign e_lane[gi] = e_data[gi*DW +: DW];
        end
    endgenerate

    // Source data and the rest of the descriptor belong to the engines, not to this block.
    assign in_unused = ^{m_src, m_src_last, dc};

    always_comb begin
        sel_c = '0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (op_in[i]) sel_c = SW'(i);
        end
    end

    assign op_legal = (op_in != '0) && ((op_in & (op_in - 1'b1)) == '0) && CAP[sel_c];

    assign e_src_empty = m_src_empty | m_src_almost_empty;
    assign e_fo_full   = m_dst_full | m_dst_almost_full;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        dst_d   = dst_q;
        last_d  = 1'b0;
        putn_d  = 1'b1;
        count_d = count_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_enable) begin
                    op_d  = op_in;
                    sel_d = sel_c;
                    if (op_legal) begin
                        state_d = RUN;
                        count_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                // Dropping enable kills the word that would otherwise be pushed next cycle.
                if (!m_enable) begin
                    state_d = IDLE;
                end else begin
                    accept = e_valid[sel_q] & ~e_fo_full;
                    if (e_done[sel_q]) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = m_enable ? END : IDLE;
            END:     state_d = HOLD;
            ERR:     state_d = HOLD;
            HOLD:    if (!m_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            dst_d  = e_lane[sel_q];
            last_d = e_last[sel_q];
            putn_d = 1'b0;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            sel_q   <= '0;
            dst_q   <= '0;
            last_q  <= 1'b0;
            putn_q  <= 1'b1;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            dst_q   <= dst_d;
            last_q  <= last_d;
            putn_q  <= putn_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign m_src_getn = (state_q == RUN) ? (e_getn[sel_q] | e_src_empty) : 1'b1;
    assign e_ce       = (state_q == RUN || state_q == FLUSH) ? op_q : '0;
    assign m_endn     = ~(state_q == END || state_q == ERR);
    assign m_dst      = dst_q;
    assign m_dst_last = last_q;
    assign m_dst_putn = putn_q;
    assign m_count    = count_q;
    assign m_err      = err_q;
    assign m_cap      = 8'(CAP);

endmodule
